uart_tx: RTL and testbench

UART transmitter for the simple-uart design: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serializes each as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) on the serial line. It is the transmit counterpart of the receive path and shares its bit timing and frame constants. Transmission is gated by a transmit-mode enable from the top level.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART frame constants and FSM state encoding
package uart_tx_pkg;

    localparam int   DATA_WIDTH           = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;

    // Shared with the receive path so TX and RX debug decode states identically.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START_TX = 2'd1,
        DATA_TX  = 2'd2,
        STOP_TX  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - single-clock byte FIFO with head-of-queue read data
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB separates the full case from the empty case.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter gated by transmit-mode enable
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  i_tx,
    input  logic                  i_tx_valid,
    input  logic [DATA_WIDTH-1:0] i_tx_byte,
    output logic                  o_tx_ready,
    output logic                  o_tx_serial,
    output logic                  o_tx_active,
    output logic                  o_tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    uart_state_e           state;
    logic [CNT_W-1:0]      clks_cnt;
    logic [2:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [LVL_W-1:0]      level;
    logic [LVL_W-1:0]      level_next;
    logic                  push;
    logic                  pop;
    logic                  last_clk;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wdata  (i_tx_byte),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Ready is registered from the post-edge fill level, so a pop never frees a slot in its own cycle.
    always_comb begin
        push       = i_tx_valid && o_tx_ready && !fifo_full;
        last_clk   = (clks_cnt == LAST_CLK);
        pop        = i_tx && !fifo_empty && ((state == IDLE) || ((state == STOP_TX) && last_clk));
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_ONE;
            2'b01:   level_next = level - LVL_ONE;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clks_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            level       <= '0;
            o_tx_ready  <= 1'b1;
            o_tx_serial <= STOP_BIT;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            level      <= level_next;
            o_tx_ready <= (level_next != FULL_LVL);

            // Line outputs follow the state one cycle later, giving the two-cycle accept-to-start latency.
            case (state)
                START_TX: o_tx_serial <= START_BIT;
                DATA_TX:  o_tx_serial <= shift[bit_idx];
                default:  o_tx_serial <= STOP_BIT;
            endcase
            o_tx_active <= (state != IDLE);
            o_tx_done   <= (state == STOP_TX) && last_clk;

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= fifo_rdata;
                        clks_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= START_TX;
                    end
                end
                START_TX: begin
                    if (last_clk) begin
                        clks_cnt <= '0;
                        state    <= DATA_TX;
                    end else begin
                        clks_cnt <= clks_cnt + CNT_ONE;
                    end
                end
                DATA_TX: begin
                    if (last_clk) begin
                        clks_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP_TX;
                        end
                    end else begin
                        clks_cnt <= clks_cnt + CNT_ONE;
                    end
                end
                STOP_TX: begin
                    if (last_clk) begin
                        clks_cnt <= '0;
                        if (pop) begin
                            shift   <= fifo_rdata;
                            bit_idx <= '0;
                            state   <= START_TX;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clks_cnt <= clks_cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a line-level frame model
module tb_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int LOGN  = 16384;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_tx = 1'b0;
    logic       i_tx_valid = 1'b0;
    logic [7:0] i_tx_byte = 8'h00;
    logic       o_tx_ready;
    logic       o_tx_serial;
    logic       o_tx_active;
    logic       o_tx_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic ser_log [LOGN];
    logic rdy_log [LOGN];
    logic act_log [LOGN];
    logic done_log[LOGN];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .i_tx        (i_tx),
        .i_tx_valid  (i_tx_valid),
        .i_tx_byte   (i_tx_byte),
        .o_tx_ready  (o_tx_ready),
        .o_tx_serial (o_tx_serial),
        .o_tx_active (o_tx_active),
        .o_tx_done   (o_tx_done)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Entry n holds the outputs as they stand after rising edge n.
    always @(negedge sysclk) begin
        if (cyc < LOGN) begin
            ser_log[cyc]  <= o_tx_serial;
            rdy_log[cyc]  <= o_tx_ready;
            act_log[cyc]  <= o_tx_active;
            done_log[cyc] <= o_tx_done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic log_bit(input int sel, input int i);
        case (sel)
            0:       return ser_log[i];
            1:       return rdy_log[i];
            2:       return act_log[i];
            default: return done_log[i];
        endcase
    endfunction

    function automatic logic win_all(input int sel, input int a, input int b, input logic v);
        for (int i = a; i < b; i++) begin
            if (log_bit(sel, i) !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int n_done(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) begin
            if (done_log[i] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge sysclk);
    endtask

    task automatic offer(input logic [7:0] b, output int acc);
        logic r;
        acc = -1;
        i_tx_valid = 1'b1;
        i_tx_byte  = b;
        for (int t = 0; t < 2000 && acc < 0; t++) begin
            r = o_tx_ready;
            @(negedge sysclk);
            if (r) acc = cyc;
        end
        i_tx_valid = 1'b0;
        check("accept", 32'(acc >= 0), 1);
        if (acc < 0) acc = cyc;
    endtask

    // An 8N1 frame starting at s: bit k is fbits[k] for cycles [s+k*CPB, s+(k+1)*CPB).
    task automatic frame_check(input int s, input logic [7:0] b, input string tag);
        logic [9:0] fbits;
        logic [7:0] rx;
        logic       a;
        logic       o;
        fbits = {1'b1, b, 1'b0};
        wait_cyc(s + FRAME + 2);
        check({tag, "_pre"}, 32'(ser_log[s-1]), 1);
        for (int k = 0; k < 10; k++) begin
            a = 1'b1;
            o = 1'b0;
            for (int j = 0; j < CPB; j++) begin
                a = a & ser_log[s + k*CPB + j];
                o = o | ser_log[s + k*CPB + j];
            end
            check($sformatf("%s_bit%0d", tag, k), {30'd0, a, o}, {30'd0, fbits[k], fbits[k]});
        end
        for (int k = 0; k < 8; k++) rx[k] = ser_log[s + (k+1)*CPB + CPB/2];
        check({tag, "_rx"}, 32'(rx), 32'(b));
        check({tag, "_done_n"}, n_done(s, s + FRAME), 1);
        check({tag, "_done_last"}, 32'(done_log[s + FRAME - 1]), 1);
        check({tag, "_active"}, 32'(win_all(2, s, s + FRAME, 1'b1)), 1);
    endtask

    initial begin
        int         acc;
        int         a5[6];
        int         s;
        int         r;
        int         prev;
        int         st[6];
        logic [7:0] bytes[6];

        // Reset and idle
        repeat (3) @(negedge sysclk);
        check("reset_vals", {o_tx_serial, o_tx_ready, o_tx_active, o_tx_done}, 4'b1100);
        rst_n = 1'b1;
        i_tx  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            check("idle", {o_tx_serial, o_tx_ready, o_tx_active, o_tx_done}, 4'b1100);
        end

        // Single byte
        offer(8'hA5, acc);
        s = acc + 2;
        frame_check(s, 8'hA5, "single");
        check("single_fall", 32'(ser_log[s-1] === 1'b1 && ser_log[s] === 1'b0), 1);
        check("single_end_act", 32'(act_log[s + FRAME]), 0);

        // Burst of five with valid held
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'h3C; bytes[4] = 8'h81;
        for (int i = 0; i < 5; i++) offer(bytes[i], a5[i]);
        check("burst_contig_accept", a5[4] - a5[0], 4);
        s = a5[0] + 2;
        for (int i = 0; i < 5; i++) frame_check(s + i*FRAME, bytes[i], $sformatf("burst%0d", i));
        check("burst_ready_drop", 32'(rdy_log[a5[0] + 4]), 0);
        check("burst_ready_held", 32'(rdy_log[s + FRAME - 2]), 0);
        check("burst_ready_rise", 32'(rdy_log[s + FRAME - 1]), 1);
        check("burst_active", 32'(win_all(2, s, s + 5*FRAME, 1'b1)), 1);
        check("burst_dones", n_done(s, s + 5*FRAME + 5), 5);

        // Transmit-mode gating
        @(negedge sysclk);
        i_tx = 1'b0;
        bytes[0] = 8'($urandom);
        bytes[1] = 8'($urandom);
        offer(bytes[0], a5[0]);
        offer(bytes[1], a5[1]);
        repeat (60) @(negedge sysclk);
        check("gate_line_idle", 32'(win_all(0, a5[0], cyc - 1, 1'b1)), 1);
        check("gate_ready", 32'(win_all(1, a5[0], cyc - 1, 1'b1)), 1);
        r = cyc;
        i_tx = 1'b1;
        s = r + 2;
        wait_cyc(s + 50);
        i_tx = 1'b0;
        frame_check(s, bytes[0], "gate0");
        wait_cyc(s + FRAME + 150);
        check("gate_held_line", 32'(win_all(0, s + FRAME, s + FRAME + 148, 1'b1)), 1);
        check("gate_held_act", 32'(act_log[s + FRAME]), 0);
        r = cyc;
        i_tx = 1'b1;
        frame_check(r + 2, bytes[1], "gate1");

        // Reset during data bit 3
        offer(8'($urandom), acc);
        s = acc + 2;
        offer(8'($urandom), a5[0]);
        wait_cyc(s + 4*CPB + 5);
        rst_n = 1'b0;
        #1;
        check("rst_async", {o_tx_serial, o_tx_ready, o_tx_active, o_tx_done}, 4'b1100);
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        r = cyc;
        repeat (200) @(negedge sysclk);
        check("rst_line_idle", 32'(win_all(0, r - 2, cyc - 1, 1'b1)), 1);
        check("rst_no_done", n_done(s, cyc - 1), 0);
        offer(8'h42, acc);
        frame_check(acc + 2, 8'h42, "post_rst");

        // Offer while full and a pop lands in the same cycle
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) offer(bytes[i], a5[i]);
        check("full_pop_accept", a5[5] - a5[0], FRAME + 2);
        s = a5[0] + 2;
        for (int i = 0; i < 6; i++) frame_check(s + i*FRAME, bytes[i], $sformatf("fullpop%0d", i));

        // Random bytes with random gaps; a frame starts at the later of back-to-back or accept+2
        prev = -1000000;
        for (int i = 0; i < 6; i++) begin
            bytes[i] = 8'($urandom);
            repeat ($urandom_range(0, 200)) @(negedge sysclk);
            offer(bytes[i], acc);
            st[i] = (prev + FRAME > acc + 2) ? prev + FRAME : acc + 2;
            prev = st[i];
        end
        for (int i = 0; i < 6; i++) frame_check(st[i], bytes[i], $sformatf("rand%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
